// File: rtl/fir_interp8.sv
// Dual-channel polyphase interpolate-by-8 FIR: one packed input beat in, one 8-sample-per-channel beat out.
// One polyphase branch is evaluated per clock for both channels; coefficients are shared and fixed at elaboration.
module fir_interp8 #(
    parameter int unsigned TAPS_PER_PHASE = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned COEF_WIDTH     = 16,
    parameter int unsigned INTERP         = 8,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned SHIFT          = 15,
    parameter logic [INTERP*TAPS_PER_PHASE*COEF_WIDTH-1:0] COEF_INIT = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  s_tvalid_i,
    output logic                                  s_tready_o,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        s_tdata_i,
    output logic                                  m_tvalid_o,
    input  logic                                  m_tready_i,
    output logic [CHANNELS*INTERP*DATA_WIDTH-1:0] m_tdata_o
);

    localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS_PER_PHASE);
    localparam int unsigned PH_W   = $clog2(INTERP);
    localparam int unsigned OUT_W  = CHANNELS * INTERP * DATA_WIDTH;

    localparam logic [PH_W-1:0]       LAST_PHASE = PH_W'(INTERP - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    state_e                        state_q;
    logic [PH_W-1:0]               phase_q;
    logic signed [DATA_WIDTH-1:0]  dl_q [CHANNELS][TAPS_PER_PHASE];
    logic [OUT_W-1:0]              out_q;
    logic                          m_tvalid_q;

    logic signed [COEF_WIDTH-1:0]  coef_c [TAPS_PER_PHASE];
    logic [DATA_WIDTH-1:0]         y_d [CHANNELS];
    logic                          accept_c;

    // Input is taken from IDLE, or from OUTPUT in the same edge the pending beat drains.
    assign s_tready_o = ~rst_i & ((state_q == IDLE) | ((state_q == OUTPUT) & m_tready_i));
    assign accept_c   = s_tvalid_i & s_tready_o;
    assign m_tvalid_o = m_tvalid_q;
    assign m_tdata_o  = out_q;

    // Branch p uses every INTERP-th coefficient starting at h[p].
    always_comb begin
        for (int k = 0; k < TAPS_PER_PHASE; k++) begin
            coef_c[k] = COEF_INIT[(k * INTERP + int'(phase_q)) * COEF_WIDTH +: COEF_WIDTH];
        end
    end

    // Full-precision MAC per channel, then floor-shift and saturate to the sample width.
    always_comb begin
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  acc;
        logic signed [ACC_W-1:0]  scaled;
        prod   = '0;
        acc    = '0;
        scaled = '0;
        y_d    = '{default: '0};
        for (int c = 0; c < CHANNELS; c++) begin
            acc = '0;
            for (int k = 0; k < TAPS_PER_PHASE; k++) begin
                prod = PROD_W'(dl_q[c][k]) * PROD_W'(coef_c[k]);
                acc  = acc + ACC_W'(prod);
            end
            scaled = acc >>> SHIFT;
            if ((&scaled[ACC_W-1:DATA_WIDTH-1]) || (~|scaled[ACC_W-1:DATA_WIDTH-1])) begin
                y_d[c] = scaled[DATA_WIDTH-1:0];
            end else if (scaled[ACC_W-1]) begin
                y_d[c] = SAT_MIN;
            end else begin
                y_d[c] = SAT_MAX;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            m_tvalid_q <= 1'b0;
            out_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < TAPS_PER_PHASE; k++) begin
                    dl_q[c][k] <= '0;
                end
            end
        end else begin
            // Accepts only happen in IDLE/OUTPUT, so the delay-line shift is state independent.
            if (accept_c) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    dl_q[c][0] <= s_tdata_i[c*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < TAPS_PER_PHASE; k++) begin
                        dl_q[c][k] <= dl_q[c][k-1];
                    end
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        state_q <= COMPUTE;
                        phase_q <= '0;
                    end
                end
                COMPUTE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        out_q[(c * INTERP + int'(phase_q)) * DATA_WIDTH +: DATA_WIDTH] <= y_d[c];
                    end
                    phase_q <= phase_q + PH_W'(1);
                    if (phase_q == LAST_PHASE) begin
                        state_q    <= OUTPUT;
                        m_tvalid_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (m_tready_i) begin
                        m_tvalid_q <= 1'b0;
                        if (accept_c) begin
                            state_q <= COMPUTE;
                            phase_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp8.sv
// Scoreboard bench for fir_interp8: two instances (unshifted ramp taps, scaled pseudo-random taps)
// share stimulus; a negedge monitor checks both against a direct convolution model.
module tb_fir_interp8;

    localparam int TAPS    = 16;
    localparam int INTERP  = 8;
    localparam int NCOEF   = INTERP * TAPS;
    localparam int SHIFT_A = 0;
    localparam int SHIFT_B = 15;

    function automatic int coef_val(input int kind, input int i);
        logic [15:0] v;
        if (kind == 0) v = 16'(i + 1);
        else           v = 16'((i * 40503 + 12345) ^ (i * i * 97));
        return int'($signed(v));
    endfunction

    function automatic logic [NCOEF*16-1:0] pack_coefs(input int kind);
        logic [NCOEF*16-1:0] v;
        v = '0;
        for (int i = 0; i < NCOEF; i++) v[i*16 +: 16] = 16'(coef_val(kind, i));
        return v;
    endfunction

    localparam logic [NCOEF*16-1:0] COEFS_A = pack_coefs(0);
    localparam logic [NCOEF*16-1:0] COEFS_B = pack_coefs(1);

    logic         clk;
    logic         rst;
    logic         s_tvalid;
    logic [31:0]  s_tdata;
    logic         m_tready;
    logic         s_tready_a, s_tready_b;
    logic         m_tvalid_a, m_tvalid_b;
    logic [255:0] m_tdata_a, m_tdata_b;

    fir_interp8 #(
        .TAPS_PER_PHASE(TAPS), .DATA_WIDTH(16), .COEF_WIDTH(16), .INTERP(INTERP),
        .CHANNELS(2), .SHIFT(SHIFT_A), .COEF_INIT(COEFS_A)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready_a),
        .s_tdata_i(s_tdata), .m_tvalid_o(m_tvalid_a), .m_tready_i(m_tready), .m_tdata_o(m_tdata_a)
    );

    fir_interp8 #(
        .TAPS_PER_PHASE(TAPS), .DATA_WIDTH(16), .COEF_WIDTH(16), .INTERP(INTERP),
        .CHANNELS(2), .SHIFT(SHIFT_B), .COEF_INIT(COEFS_B)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready_b),
        .s_tdata_i(s_tdata), .m_tvalid_o(m_tvalid_b), .m_tready_i(m_tready), .m_tdata_o(m_tdata_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference model: most recent accepted sample at index 0.
    int hist0[$];
    int hist1[$];

    function automatic logic [15:0] model_sample(input int kind, input int ch, input int p);
        longint acc;
        int     n;
        int     x;
        acc = 0;
        n = (ch == 0) ? hist0.size() : hist1.size();
        for (int k = 0; k < n; k++) begin
            x = (ch == 0) ? hist0[k] : hist1[k];
            acc += longint'(x) * longint'(coef_val(kind, INTERP * k + p));
        end
        acc = acc >>> ((kind == 0) ? SHIFT_A : SHIFT_B);
        if (acc > 32767)       acc = 32767;
        else if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    function automatic logic [255:0] model_beat(input int kind);
        logic [255:0] v;
        v = '0;
        for (int ch = 0; ch < 2; ch++)
            for (int p = 0; p < INTERP; p++)
                v[ch*128 + p*16 +: 16] = model_sample(kind, ch, p);
        return v;
    endfunction

    typedef struct packed {
        logic [255:0] a;
        logic [255:0] b;
        int           rise;
    } exp_t;

    exp_t sb[$];
    exp_t ent;
    bit   exp_v;
    bit   exp_rdy;

    // Monitor: everything here refers to the upcoming posedge.
    initial begin
        forever begin
            @(negedge clk);
            exp_v   = (sb.size() > 0) && (cyc >= sb[0].rise);
            exp_rdy = !rst && ((sb.size() == 0) || (exp_v && m_tready));
            check_bit("s_tready_a", s_tready_a, exp_rdy);
            check_bit("s_tready_b", s_tready_b, exp_rdy);
            check_bit("m_tvalid_a", m_tvalid_a, exp_v);
            check_bit("m_tvalid_b", m_tvalid_b, exp_v);
            if (exp_v) begin
                check_word("m_tdata_a", m_tdata_a, sb[0].a);
                check_word("m_tdata_b", m_tdata_b, sb[0].b);
            end
            if (rst) begin
                sb.delete();
                hist0.delete();
                hist1.delete();
            end else begin
                if (exp_v && m_tready) void'(sb.pop_front());
                if (s_tvalid && exp_rdy) begin
                    hist0.push_front(int'($signed(s_tdata[15:0])));
                    hist1.push_front(int'($signed(s_tdata[31:16])));
                    if (hist0.size() > TAPS) void'(hist0.pop_back());
                    if (hist1.size() > TAPS) void'(hist1.pop_back());
                    ent.a    = model_beat(0);
                    ent.b    = model_beat(1);
                    ent.rise = cyc + 9;
                    sb.push_back(ent);
                end
            end
        end
    end

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_tready_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout at cycle %0d: got no s_tready expected s_tready within 300 cycles", cyc);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1);
        s_tvalid = 1'b1;
        s_tdata  = {c1, c0};
        wait_accept();
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_tvalid_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL valid_timeout at cycle %0d: got no m_tvalid expected m_tvalid within 60 cycles", cyc);
        end
    endtask

    function automatic logic [15:0] rnd16();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return 16'($urandom);
        if (sel == 1) return ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
        return 16'(int'($urandom_range(0, 40)) - 20);
    endfunction

    initial begin
        bit accepted;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_word("reset_tdata_a", m_tdata_a, '0);
        check_word("reset_tdata_b", m_tdata_b, '0);
        repeat (2) @(posedge clk);
        #1;

        // Impulse on CH0 followed by 15 zero beats, back to back.
        send(16'd1, 16'd0);
        for (int i = 0; i < 15; i++) send(16'd0, 16'd0);

        // Channel independence and saturation.
        send(16'd2, 16'hFFFD);
        for (int i = 0; i < 16; i++) send(16'h7FFF, 16'h8000);

        // Output stall with the next input already waiting.
        repeat (12) @(posedge clk);
        #1 m_tready = 1'b0;
        send(16'h0123, 16'hFF00);
        s_tvalid = 1'b1;
        s_tdata  = {16'hFFC0, 16'h0040};
        wait_valid();
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
        wait_accept();
        repeat (12) @(posedge clk);
        #1;

        // Reset while branch 4 is about to be computed.
        send(16'h1000, 16'h1000);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(16'd0, 16'd0);
        repeat (20) @(posedge clk);
        #1;

        // Isolated single-cycle input pulses.
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {rnd16(), rnd16()};
            @(posedge clk);
            #1 s_tvalid = 1'b0;
            repeat (19) @(posedge clk);
            #1;
        end

        // Random traffic with random output backpressure.
        for (int n = 0; n < 1500; n++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            if (!s_tvalid && ($urandom_range(0, 2) == 0)) begin
                s_tvalid = 1'b1;
                s_tdata  = {rnd16(), rnd16()};
            end
            @(negedge clk);
            accepted = s_tvalid && s_tready_a;
            @(posedge clk);
            #1;
            if (accepted) s_tvalid = 1'b0;
        end

        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain at cycle %0d: got %0d beats outstanding expected 0", cyc, sb.size());
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
